// File: rtl/model_readout.sv
// Streams the DPLL solution to the host as DIMACS-style signed literals, one per variable,
// followed by a 0 terminator, over a valid/ready handshake.
module model_readout #(
    parameter int unsigned MAX_VARS = 256,
    parameter int unsigned IDX_W    = $clog2(MAX_VARS),
    parameter int unsigned CNT_W    = $clog2(MAX_VARS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             solve_done,
    input  logic             solve_sat,
    input  logic [CNT_W-1:0] num_vars,
    input  logic             start,
    output logic [IDX_W-1:0] assign_rd_addr,
    input  logic [1:0]       assign_rd_data,
    output logic             out_valid,
    output logic [31:0]      out_literal,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] unassigned_cnt,
    output logic             illegal_seen
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StCapt,
        StEmit,
        StTerm,
        StDone
    } state_t;

    state_t           r_state;
    state_t           w_state_d;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_nv;
    logic [31:0]      r_literal;
    logic [CNT_W-1:0] r_unassigned;
    logic             r_illegal;

    logic             w_start_acc;
    logic             w_hs;
    logic             w_last_var;
    logic [CNT_W-1:0] w_nv;
    logic [31:0]      w_var;

    assign w_start_acc = start && (r_state == StIdle) && solve_done;
    assign w_hs        = out_valid && out_ready;
    assign w_nv        = (num_vars > CNT_W'(MAX_VARS)) ? CNT_W'(MAX_VARS) : num_vars;
    assign w_last_var  = (CNT_W'(r_idx) == (r_nv - CNT_W'(1)));
    // Variable number is one above its assignment index.
    assign w_var       = 32'(r_idx) + 32'd1;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_start_acc) begin
                    w_state_d = (solve_sat && (w_nv != '0)) ? StAddr : StTerm;
                end
            end
            StAddr: w_state_d = StCapt;
            StCapt: w_state_d = StEmit;
            StEmit: begin
                if (w_hs) begin
                    w_state_d = w_last_var ? StTerm : StAddr;
                end
            end
            StTerm: begin
                if (w_hs) begin
                    w_state_d = StDone;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_nv         <= '0;
            r_literal    <= '0;
            r_unassigned <= '0;
            r_illegal    <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_nv         <= w_nv;
                r_idx        <= '0;
                r_unassigned <= '0;
                r_illegal    <= 1'b0;
            end
            if (r_state == StCapt) begin
                case (assign_rd_data)
                    2'b10: r_literal <= w_var;
                    2'b01: r_literal <= -w_var;
                    2'b00: begin
                        r_literal <= -w_var;
                        if (r_unassigned != r_nv) begin
                            r_unassigned <= r_unassigned + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_literal <= -w_var;
                        r_illegal <= 1'b1;
                    end
                endcase
            end
            if ((r_state == StEmit) && w_hs && !w_last_var) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    assign assign_rd_addr = r_idx;
    assign out_valid      = (r_state == StEmit) || (r_state == StTerm);
    assign out_literal    = (r_state == StEmit) ? r_literal : 32'd0;
    assign out_last       = (r_state == StTerm);
    assign busy           = (r_state != StIdle);
    assign done           = (r_state == StDone);
    assign unassigned_cnt = r_unassigned;
    assign illegal_seen   = r_illegal;

endmodule

// File: tb/tb_model_readout.sv
// Directed and randomized bench for model_readout; expected streams are built from the
// assignment array with plain arithmetic and compared beat by beat.
module tb_model_readout;

    localparam int unsigned MAX_VARS = 256;
    localparam int unsigned IDX_W    = 8;
    localparam int unsigned CNT_W    = 9;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             solve_done;
    logic             solve_sat;
    logic [CNT_W-1:0] num_vars;
    logic             start;
    logic [IDX_W-1:0] assign_rd_addr;
    logic [1:0]       assign_rd_data;
    logic             out_valid;
    logic [31:0]      out_literal;
    logic             out_last;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] unassigned_cnt;
    logic             illegal_seen;

    logic [1:0] mem [MAX_VARS];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         hs_cnt   = 0;
    logic       hs_pend  = 1'b0;
    int         hs0;
    int         waited;

    model_readout #(
        .MAX_VARS(MAX_VARS),
        .IDX_W   (IDX_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .solve_done    (solve_done),
        .solve_sat     (solve_sat),
        .num_vars      (num_vars),
        .start         (start),
        .assign_rd_addr(assign_rd_addr),
        .assign_rd_data(assign_rd_data),
        .out_valid     (out_valid),
        .out_literal   (out_literal),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done),
        .unassigned_cnt(unassigned_cnt),
        .illegal_seen  (illegal_seen)
    );

    always #5 clk = ~clk;

    // Assignment array with a 1-cycle read latency.
    always @(posedge clk) assign_rd_data <= mem[assign_rd_addr];

    always @(negedge clk) begin
        #1;
        hs_pend = out_valid && out_ready;
    end
    always @(posedge clk) if (rst_n && hs_pend) hs_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_readout(input int nv_req, input bit sat, input int stall, input bit noisy);
        int nv;
        int exp_q[$];
        int exp_un;
        bit exp_ill;
        int hs_start;
        int wcnt;
        bit last_beat;
        nv      = (nv_req > 256) ? 256 : nv_req;
        exp_un  = 0;
        exp_ill = 0;
        if (sat) begin
            for (int v = 1; v <= nv; v++) begin
                exp_q.push_back((mem[v-1] == 2'b10) ? v : -v);
                if (mem[v-1] == 2'b00) exp_un++;
                if (mem[v-1] == 2'b11) exp_ill = 1'b1;
            end
        end
        exp_q.push_back(0);

        @(negedge clk);
        solve_done = 1'b1;
        solve_sat  = sat;
        num_vars   = CNT_W'(nv_req);
        start      = 1'b1;
        out_ready  = (stall == 0);
        hs_start   = hs_cnt;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int b = 0; b < exp_q.size(); b++) begin
            last_beat = (b == exp_q.size() - 1);
            if (noisy && last_beat) begin
                start      = 1'b0;
                solve_done = 1'b1;
            end
            if (!sat) check("addr_stuck", 32'(assign_rd_addr), 32'd0);
            wcnt = 0;
            while (!out_valid && wcnt < 20) begin
                if (noisy) begin
                    start      = 1'($urandom);
                    solve_done = 1'($urandom);
                    solve_sat  = 1'($urandom);
                    num_vars   = CNT_W'($urandom);
                end
                @(negedge clk);
                wcnt++;
            end
            check("valid_seen", 32'(out_valid), 32'd1);
            check("beat_spacing", wcnt, last_beat ? 32'd0 : 32'd2);
            for (int s = 0; s < stall; s++) begin
                check("hold_literal", out_literal, exp_q[b]);
                check("hold_last", 32'(out_last), 32'(last_beat));
                check("hold_valid", 32'(out_valid), 32'd1);
                @(negedge clk);
            end
            out_ready = 1'b1;
            check("literal", out_literal, exp_q[b]);
            check("last", 32'(out_last), 32'(last_beat));
            @(negedge clk);
            out_ready = (stall == 0);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("valid_after_term", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("done_clear", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("handshakes", hs_cnt - hs_start, exp_q.size());
        check("unassigned_cnt", 32'(unassigned_cnt), exp_un);
        check("illegal_seen", 32'(illegal_seen), 32'(exp_ill));
        if (!sat) check("addr_stuck_end", 32'(assign_rd_addr), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        solve_done = 1'b0;
        solve_sat  = 1'b0;
        num_vars   = '0;
        start      = 1'b0;
        out_ready  = 1'b0;
        for (int i = 0; i < MAX_VARS; i++) mem[i] = 2'b00;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_literal", out_literal, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(assign_rd_addr), 32'd0);
        check("rst_unassigned", 32'(unassigned_cnt), 32'd0);
        check("rst_illegal", 32'(illegal_seen), 32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // SAT, three variables, host always ready
        mem[0] = 2'b10; mem[1] = 2'b01; mem[2] = 2'b10;
        run_readout(3, 1'b1, 0, 1'b0);
        // UNSAT: terminator only
        run_readout(3, 1'b0, 0, 1'b0);
        // Same stream under 5-cycle backpressure per beat
        run_readout(3, 1'b1, 5, 1'b0);
        // Unassigned and illegal states
        mem[0] = 2'b10; mem[1] = 2'b00; mem[2] = 2'b11;
        run_readout(3, 1'b1, 0, 1'b0);

        // Start without solve_done is ignored
        @(negedge clk);
        solve_done = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("nodone_busy", 32'(busy), 32'd0);
        check("nodone_valid", 32'(out_valid), 32'd0);

        // Oversized count clamps to 256; input noise while busy is ignored
        for (int i = 0; i < MAX_VARS; i++) mem[i] = 2'($urandom);
        run_readout(300, 1'b1, 0, 1'b1);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < MAX_VARS; i++) mem[i] = 2'($urandom);
            run_readout(int'($urandom_range(1, 40)), 1'b1, int'($urandom_range(0, 2)), 1'b0);
        end

        // Reset mid-stream after the second literal is accepted
        for (int i = 0; i < MAX_VARS; i++) mem[i] = 2'($urandom);
        mem[0] = 2'b00;
        @(negedge clk);
        solve_done = 1'b1;
        solve_sat  = 1'b1;
        num_vars   = CNT_W'(10);
        start      = 1'b1;
        out_ready  = 1'b1;
        hs0        = hs_cnt;
        @(negedge clk);
        start  = 1'b0;
        waited = 0;
        while ((hs_cnt - hs0) < 2 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("two_accepted", hs_cnt - hs0, 32'd2);
        check("pre_rst_unassigned", 32'(unassigned_cnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_literal", out_literal, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_addr", 32'(assign_rd_addr), 32'd0);
        check("mid_rst_unassigned", 32'(unassigned_cnt), 32'd0);
        check("mid_rst_illegal", 32'(illegal_seen), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_readout(10, 1'b1, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
